mul_iter_shift_add: RTL and testbench

- Parametrised, sequential successor to the team's fixed 16-bit combinational unsigned multiplier.
- Iterative shift-add multiplier for WIDTH x WIDTH operands. Returns the full 2*WIDTH product, with per-operation signed/unsigned mode.
- Processes BITS_PER_CYCLE multiplier bits per clock, trading latency for area.
- Sits behind a valid/ready request port and a valid/ready result port. Used by datapath blocks that cannot afford a flat array multiplier.

---
 rtl/mul_iter_shift_add.sv | 231 +++++++++++++++++++++++
 tb/tb_mul_iter_shift_add.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter_shift_add.sv
// ---------------------------------------------------------------------------
// mul_iter_shift_add
//
// Iterative shift-add multiplier for WIDTH x WIDTH operands producing the
// full, exact 2*WIDTH product. Each operation may be signed (two's
// complement) or unsigned. BITS_PER_CYCLE multiplier bits are consumed
// per clock, so an operation needs N = WIDTH/BITS_PER_CYCLE CALC cycles.
//
// Operands are reduced to unsigned magnitudes at accept. The magnitudes are
// multiplied by shift-add, and the sign is applied once when the result is
// registered on entry to DONE.
//
// Optional feature (compile-time macro MUL_ITER_EARLY_EXIT_EN):
//   When defined, CALC ends as soon as the remaining multiplier bits are
//   all zero, so latency follows the highest set bit of |B|. When
//   undefined, every operation takes exactly N CALC cycles and no
//   early-exit logic is built.
//
// Parameters:
//   WIDTH          operand width (>= 2)
//   BITS_PER_CYCLE multiplier bits consumed per CALC cycle (divides WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; aborts any operation
//   in_valid     request valid
//   in_ready     block can accept a request (high only in IDLE)
//   multiplicand operand A
//   multiplier   operand B
//   is_signed    1 = two's-complement operands, sampled at accept
//   out_valid    product valid (high only in DONE)
//   out_ready    consumer takes the product
//   product      A*B, 2*WIDTH bits, held until the next result
//   busy         high in CALC or DONE
// ---------------------------------------------------------------------------
module mul_iter_shift_add #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    // Elaboration-time parameter sanity.
    if (WIDTH < 2) begin : gen_bad_width
        $error("mul_iter_shift_add: WIDTH must be >= 2");
    end
    if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : gen_bad_bpc
        $error("mul_iter_shift_add: BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Multiplicand magnitude pre-shifted to the weight of the current digit,
    // so each step adds without a variable shifter.
    logic [PW-1:0]    a_sh_q, a_sh_d;
    // Multiplier magnitude bits not yet consumed.
    logic [WIDTH-1:0] b_rem_q, b_rem_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    prod_q, prod_d;

    // ------------------------------------------------------------------
    // Operand conditioning (used only on the accepting edge)
    // ------------------------------------------------------------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        a_neg = is_signed & multiplicand[WIDTH-1];
        b_neg = is_signed & multiplier[WIDTH-1];
        // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
        // unsigned magnitude.
        mag_a = a_neg ? -multiplicand : multiplicand;
        mag_b = b_neg ? -multiplier   : multiplier;
    end

    // ------------------------------------------------------------------
    // One shift-add step
    // ------------------------------------------------------------------
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [PW-1:0]             partial;
    logic [PW-1:0]             acc_sum;
    logic [WIDTH-1:0]          b_shifted;
    logic                      calc_last;

    always_comb begin
        digit   = b_rem_q[BITS_PER_CYCLE-1:0];
        partial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (digit[i]) begin
                partial = partial + (a_sh_q << i);
            end
        end
        acc_sum   = acc_q + partial;
        b_shifted = b_rem_q >> BITS_PER_CYCLE;
    end

`ifdef MUL_ITER_EARLY_EXIT_EN
    // Nothing left to add once the remaining multiplier bits are zero.
    assign calc_last = (cnt_q == '0) || (b_shifted == '0);
`else
    assign calc_last = (cnt_q == '0);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (calc_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StCalc) || (state_q == StDone);
    end

    assign product = prod_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_sh_d  = a_sh_q;
        b_rem_d = b_rem_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = PW'(mag_a);
                    b_rem_d = mag_b;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(N - 1);
                end
            end
            StCalc: begin
                acc_d   = acc_sum;
                a_sh_d  = a_sh_q << BITS_PER_CYCLE;
                b_rem_d = b_shifted;
                if (calc_last) begin
                    cnt_d = '0;
                    // Negating a zero magnitude gives zero, so no -0.
                    prod_d = neg_q ? -acc_sum : acc_sum;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_rem_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_rem_q <= b_rem_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_mul_iter_shift_add.sv
// ---------------------------------------------------------------------------
// tb_mul_iter_shift_add
//
// Self-checking bench with two instances: WIDTH=16/BPC=1 for directed cases
// and WIDTH=32/BPC=4 for randomized signed/unsigned pairs. Expected products
// are queued when a request is driven and compared when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_mul_iter_shift_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-bit, 1 bit per cycle
    logic        v16, r16, s16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    // 32-bit, 4 bits per cycle
    logic        v32, r32, s32, ov32, or32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    mul_iter_shift_add #(
        .WIDTH          (16),
        .BITS_PER_CYCLE (1)
    ) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (v16),
        .in_ready     (r16),
        .multiplicand (a16),
        .multiplier   (b16),
        .is_signed    (s16),
        .out_valid    (ov16),
        .out_ready    (or16),
        .product      (p16),
        .busy         (busy16)
    );

    mul_iter_shift_add #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (4)
    ) u_dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (v32),
        .in_ready     (r32),
        .multiplicand (a32),
        .multiplier   (b32),
        .is_signed    (s32),
        .out_valid    (ov32),
        .out_ready    (or32),
        .product      (p32),
        .busy         (busy32)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] sb16[$];
    logic [63:0] sb32[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] golden16(input logic [15:0] a, input logic [15:0] b,
                                             input logic sgn);
        int sa, sb;
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'({16'b0, a});
            sb = int'({16'b0, b});
        end
        return 32'(sa * sb);
    endfunction

    function automatic logic [63:0] golden32(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    // Expected CALC edges for a multiplier magnitude.
    function automatic int exp_lat(input logic [63:0] mag, input int n, input int bpc);
`ifdef MUL_ITER_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 64; i++) begin
            if (mag[i]) msb = i;
        end
        if (msb < 0) return 1;
        return (msb + bpc) / bpc;
`else
        return n + 0 * int'(mag[0]) + 0 * bpc;
`endif
    endfunction

    function automatic logic [63:0] mag_of(input logic [63:0] b, input int w, input logic sgn);
        logic [63:0] m;
        m = b;
        if (sgn && b[w-1]) begin
            m = (~b + 64'd1) & ((64'd1 << w) - 64'd1);
        end
        return m;
    endfunction

    // Directed operation on the 16-bit instance. 'hold' cycles of
    // out_ready=0 with a competing request held on in_valid.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sgn, input logic [31:0] exp, input int hold);
        int          cyc;
        int          lat;
        logic        calc_ok;
        logic        hold_ok;
        logic [31:0] held;
        logic [63:0] want;
        lat = exp_lat(mag_of({48'b0, b}, 16, sgn), 16, 1);
        cyc = 0;
        while (!r16 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_in_ready"}, 64'(r16), 64'd1);
        a16 = a; b16 = b; s16 = sgn; v16 = 1'b1;
        sb16.push_back({32'b0, exp});
        @(posedge clk); #1;
        v16 = 1'b0;
        // Scramble operands; the latched copies must be used.
        a16 = ~a; b16 = b ^ 16'h5a5a; s16 = ~sgn;
        cyc = 0;
        calc_ok = 1'b1;
        while (!ov16 && cyc < 200) begin
            calc_ok &= !r16 && busy16;
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_calc_flags"}, 64'(calc_ok), 64'd1);
        held = p16;
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            v16 = 1'b1;
            @(posedge clk); #1;
            hold_ok &= ov16 && !r16 && (p16 == held);
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(hold_ok), 64'd1);
        v16 = 1'b0;
        if (sb16.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            want = 64'hx;
        end else begin
            want = sb16.pop_front();
        end
        check({tag, "_product"}, {32'b0, p16}, want);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check({tag, "_after_hs"}, {61'b0, ov16, r16, (p16 == held)}, 64'b011);
    endtask

    task automatic op32(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn);
        int          cyc;
        logic [63:0] want;
        cyc = 0;
        while (!r32 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        a32 = a; b32 = b; s32 = sgn; v32 = 1'b1;
        sb32.push_back(golden32(a, b, sgn));
        @(posedge clk); #1;
        v32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        cyc = 0;
        while (!ov32 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check($sformatf("rnd%0d_latency", idx), 64'(cyc),
              64'(exp_lat(mag_of({32'b0, b}, 32, sgn), 8, 4)));
        if (sb32.size() == 0) begin
            check($sformatf("rnd%0d_sb_empty", idx), 64'd0, 64'd1);
            want = 64'hx;
        end else begin
            want = sb32.pop_front();
        end
        if (want !== p32) begin
            $display("  rnd%0d operands a=0x%0h b=0x%0h signed=%0d", idx, a, b, sgn);
        end
        check($sformatf("rnd%0d_product", idx), p32, want);
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        never_valid;
        logic [31:0] ca [8];
        logic [31:0] cb [8];

        rst_n = 1'b0;
        v16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
        v32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(r16), 64'd1);
        check("reset_out_valid", 64'(ov16), 64'd0);
        check("reset_busy", 64'(busy16), 64'd0);
        check("reset_product", {32'b0, p16}, 64'd0);
        check("reset32_flags", {61'b0, r32, ov32, busy32}, 64'b100);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op16("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);
        op16("s_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
        op16("s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 0);
        op16("u_fffdx7", 16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, 5);
        op16("s_zero_neg", 16'h0000, 16'hFFF0, 1'b1, 32'h0, 0);
        op16("s_mixed", 16'h1234, 16'h8001, 1'b1, golden16(16'h1234, 16'h8001, 1'b1), 2);

        // Abort at CALC cycle 7 with a synchronous reset.
        a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 1'b0; v16 = 1'b1;
        sb16.push_back(64'hFFFE0001);
        @(posedge clk); #1;
        v16 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy16), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb16.delete();
        check("abort_out_valid", 64'(ov16), 64'd0);
        check("abort_product", {32'b0, p16}, 64'd0);
        check("abort_in_ready", 64'(r16), 64'd1);
        never_valid = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            never_valid &= !ov16 && !busy16;
        end
        check("abort_no_result", 64'(never_valid), 64'd1);
        op16("post_abort", 16'd3, 16'd5, 1'b0, 32'd15, 0);

        // Latency-sensitive multipliers.
        op16("b_one", 16'h1234, 16'h0001, 1'b0, 32'h00001234, 0);
        op16("b_zero", 16'hABCD, 16'h0000, 1'b0, 32'h0, 0);
        op16("b_msb", 16'h0003, 16'h8000, 1'b0, 32'h00018000, 0);

        // 32-bit, 4 bits per cycle: corners first, then random.
        ca = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF,
               32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hDEAD_BEEF};
        cb = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001,
               32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0000_000F};
        for (int i = 0; i < 1000; i++) begin
            if (i < 16) begin
                op32(i, ca[i % 8], cb[i % 8], 1'(i / 8));
            end else begin
                op32(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
